// File: rtl/fft_frame_framer.sv
// fft_frame_framer: re-frames an AXI-Stream of complex samples into FRAME_LEN-beat FFT frames.
// Define FFT_FRAMER_STATS_EN to add the frames_out / pad_beats / cut_frames counters.
module fft_frame_framer #(
  parameter int BW        = 32,
  parameter int BWB       = BW / 8,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk_line,
  input  logic             clk_line_rst_high,
  input  logic             plain_start_of_processing,
  input  logic             stream_in_TVALID,
  input  logic [BW-1:0]    stream_in_TDATA,
  input  logic [BWB-1:0]   stream_in_TKEEP,
  input  logic             stream_in_TLAST,
  output logic             stream_in_TREADY,
  output logic             stream_out_TVALID,
  output logic [BW-1:0]    stream_out_TDATA,
  output logic [BWB-1:0]   stream_out_TKEEP,
  output logic             stream_out_TLAST,
  input  logic             stream_out_TREADY,
  output logic [CNT_W-1:0] frame_idx
`ifdef FFT_FRAMER_STATS_EN
  ,
  output logic [31:0]      frames_out,
  output logic [31:0]      pad_beats,
  output logic [15:0]      cut_frames
`endif
);

  typedef enum logic {
    PASS = 1'b0,
    PAD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             out_free;
  logic             in_ready;
  logic             in_fire;
  logic             pad_fire;
  logic             load;
  logic             at_last;
  logic             at_first;
  logic [BWB-1:0]   unused_keep;

  // Samples are always whole, so input byte enables carry no information.
  assign unused_keep = stream_in_TKEEP;

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      state <= PASS;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      PASS: begin
        if (in_fire) begin
          if ((stream_in_TLAST || plain_start_of_processing) && !at_last) begin
            state_nxt = PAD;
          end
        end else if (plain_start_of_processing && !at_first) begin
          state_nxt = PAD;
        end
      end
      PAD: begin
        if (pad_fire && at_last) begin
          state_nxt = PASS;
        end
      end
      default: state_nxt = PASS;
    endcase
  end

  always_comb begin
    out_free = !stream_out_TVALID || stream_out_TREADY;
    in_ready = !clk_line_rst_high && (state == PASS) && out_free;
    in_fire  = stream_in_TVALID && in_ready;
    pad_fire = (state == PAD) && out_free;
    load     = in_fire || pad_fire;
    at_last  = (cnt == LAST);
    at_first = (cnt == '0);
  end

  assign stream_in_TREADY = in_ready;

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      stream_out_TVALID <= 1'b0;
      stream_out_TDATA  <= '0;
      stream_out_TKEEP  <= '0;
      stream_out_TLAST  <= 1'b0;
      frame_idx         <= '0;
      cnt               <= '0;
    end else if (load) begin
      stream_out_TVALID <= 1'b1;
      stream_out_TDATA  <= in_fire ? stream_in_TDATA : '0;
      stream_out_TKEEP  <= '1;
      stream_out_TLAST  <= at_last;
      frame_idx         <= cnt;
      cnt               <= cnt + CNT_W'(1);
    end else if (stream_out_TREADY) begin
      stream_out_TVALID <= 1'b0;
    end
  end

`ifdef FFT_FRAMER_STATS_EN
  logic out_hs;
  logic out_pad;
  logic cut_pend;

  assign out_hs = stream_out_TVALID && stream_out_TREADY;

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      out_pad <= 1'b0;
    end else if (load) begin
      out_pad <= pad_fire;
    end
  end

  // A cut only counts once the packet is seen to continue past it.
  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      frames_out <= '0;
      pad_beats  <= '0;
      cut_frames <= '0;
      cut_pend   <= 1'b0;
    end else begin
      if (out_hs && stream_out_TLAST && (frames_out != '1)) begin
        frames_out <= frames_out + 32'd1;
      end
      if (out_hs && out_pad && (pad_beats != '1)) begin
        pad_beats <= pad_beats + 32'd1;
      end
      if (in_fire) begin
        cut_pend <= at_last && !stream_in_TLAST;
        if (cut_pend && (cut_frames != '1)) begin
          cut_frames <= cut_frames + 16'd1;
        end
      end else if (plain_start_of_processing) begin
        cut_pend <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_framer.sv
// tb_fft_frame_framer: directed checks of framing, padding, cutting, stalls, realign, reset.
// FRAME_LEN=8; stats checks compile in only with FFT_FRAMER_STATS_EN.
module tb_fft_frame_framer;
  localparam int BW  = 32;
  localparam int BWB = 4;
  localparam int FL  = 8;
  localparam int CW  = 3;

  logic           clk  = 1'b0;
  logic           rst  = 1'b1;
  logic           sop  = 1'b0;
  logic           iv   = 1'b0;
  logic [BW-1:0]  id   = '0;
  logic [BWB-1:0] ik   = 4'h3;
  logic           il   = 1'b0;
  logic           ir;
  logic           ov;
  logic [BW-1:0]  od;
  logic [BWB-1:0] ok;
  logic           ol;
  logic           ordy = 1'b1;
  logic [CW-1:0]  fidx;
`ifdef FFT_FRAMER_STATS_EN
  logic [31:0]    frames_out;
  logic [31:0]    pad_beats;
  logic [15:0]    cut_frames;
`endif

  fft_frame_framer #(
    .BW(BW), .BWB(BWB), .FRAME_LEN(FL), .CNT_W(CW)
  ) dut (
    .clk_line(clk),
    .clk_line_rst_high(rst),
    .plain_start_of_processing(sop),
    .stream_in_TVALID(iv),
    .stream_in_TDATA(id),
    .stream_in_TKEEP(ik),
    .stream_in_TLAST(il),
    .stream_in_TREADY(ir),
    .stream_out_TVALID(ov),
    .stream_out_TDATA(od),
    .stream_out_TKEEP(ok),
    .stream_out_TLAST(ol),
    .stream_out_TREADY(ordy),
    .frame_idx(fidx)
`ifdef FFT_FRAMER_STATS_EN
    ,
    .frames_out(frames_out),
    .pad_beats(pad_beats),
    .cut_frames(cut_frames)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ir_lo = 0;
  bit bp_en = 1'b0;
  bit stall_chk = 1'b0;

  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [BW-1:0] p_d = '0;
  logic          p_l = 1'b0;
  logic [CW-1:0] p_i = '0;

  logic [BW-1:0] q_d[$];
  logic          q_l[$];
  logic [CW-1:0] q_i[$];
  int            q_c[$];
  int            a_c[$];
  logic [BW-1:0] e_d[$];
  logic          e_l[$];
  logic [CW-1:0] e_i[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      ordy = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (stall_chk && pv && !pr && !rst) begin
      check("stall_v", 32'(ov), 32'd1);
      check("stall_d", od, p_d);
      check("stall_l", 32'(ol), 32'(p_l));
      check("stall_i", 32'(fidx), 32'(p_i));
    end
    pv = ov;
    pr = ordy;
    p_d = od;
    p_l = ol;
    p_i = fidx;
    if (ov && ordy) begin
      q_d.push_back(od);
      q_l.push_back(ol);
      q_i.push_back(fidx);
      q_c.push_back(cyc);
    end
    if (iv && ir) a_c.push_back(cyc);
    if (!ir && !rst) ir_lo++;
  end

  task automatic clr();
    q_d.delete(); q_l.delete(); q_i.delete(); q_c.delete(); a_c.delete();
    e_d.delete(); e_l.delete(); e_i.delete();
    ir_lo = 0;
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic l, input int i);
    e_d.push_back(d);
    e_l.push_back(l);
    e_i.push_back(CW'(i));
  endtask

  task automatic cmp_q(input string tag);
    check({tag, "_n"}, 32'(q_d.size()), 32'(e_d.size()));
    for (int k = 0; k < e_d.size() && k < q_d.size(); k++) begin
      check($sformatf("%s_d%0d", tag, k), q_d[k], e_d[k]);
      check($sformatf("%s_l%0d", tag, k), 32'(q_l[k]), 32'(e_l[k]));
      check($sformatf("%s_i%0d", tag, k), 32'(q_i[k]), 32'(e_i[k]));
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bit done = 1'b0;
    iv = 1'b1;
    id = d;
    il = last;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (ir) done = 1'b1;
      @(posedge clk);
      #1;
    end
    iv = 1'b0;
    il = 1'b0;
    id = '0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int nl;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", 32'(ov), 32'd0);
    check("rst_od", od, 32'd0);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_ol", 32'(ol), 32'd0);
    check("rst_idx", 32'(fidx), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 32'(ir), 32'd1);

    // exact-length frame
    clr();
    for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
    idle(4);
    for (int k = 0; k < 8; k++) exp_beat(32'(k + 1), k == 7, k);
    cmp_q("exact");
    for (int k = 0; k < 8; k++) begin
      if (k < q_c.size() && k < a_c.size()) begin
        check($sformatf("lat%0d", k), 32'(q_c[k]), 32'(a_c[0] + 1 + k));
        check($sformatf("in_gap%0d", k), 32'(a_c[k]), 32'(a_c[0] + k));
      end
    end
    check("keep_ones", 32'(ok), 32'hF);
`ifdef FFT_FRAMER_STATS_EN
    check("st_frames1", frames_out, 32'd1);
`endif

    // short packet padded
    clr();
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b1);
    idle(10);
    exp_beat(32'hA, 1'b0, 0);
    exp_beat(32'hB, 1'b0, 1);
    exp_beat(32'hC, 1'b0, 2);
    for (int k = 3; k < 8; k++) exp_beat(32'd0, k == 7, k);
    cmp_q("short");
    check("pad_ir_lo", 32'(ir_lo), 32'd5);
`ifdef FFT_FRAMER_STATS_EN
    check("st_pad2", pad_beats, 32'd5);
    check("st_frames2", frames_out, 32'd2);
`endif

    // long packet cut
    clr();
    for (int i = 1; i <= 20; i++) send(32'h100 + 32'(i), i == 20);
    idle(10);
    for (int k = 0; k < 24; k++)
      exp_beat(k < 20 ? 32'h101 + 32'(k) : 32'd0, (k % 8) == 7, k % 8);
    cmp_q("long");
`ifdef FFT_FRAMER_STATS_EN
    check("st_cut3", 32'(cut_frames), 32'd2);
    check("st_frames3", frames_out, 32'd5);
    check("st_pad3", pad_beats, 32'd9);
`endif

    // random backpressure
    clr();
    stall_chk = 1'b1;
    bp_en = 1'b1;
    for (int i = 0; i < 32; i++) send(32'h200 + 32'(i), (i % 8) == 7);
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    ordy = 1'b1;
    idle(6);
    stall_chk = 1'b0;
    for (int k = 0; k < 32; k++) exp_beat(32'h200 + 32'(k), (k % 8) == 7, k % 8);
    cmp_q("bp");
    nl = 0;
    foreach (q_l[k]) if (q_l[k]) nl++;
    check("bp_lasts", 32'(nl), 32'd4);
`ifdef FFT_FRAMER_STATS_EN
    check("st_frames4", frames_out, 32'd9);
    check("st_cut4", 32'(cut_frames), 32'd2);
`endif

    // realign mid-frame
    clr();
    for (int i = 1; i <= 5; i++) send(32'h300 + 32'(i), 1'b0);
    sop = 1'b1;
    @(posedge clk);
    #1;
    sop = 1'b0;
    send(32'h3AA, 1'b1);
    idle(12);
    for (int k = 0; k < 5; k++) exp_beat(32'h301 + 32'(k), 1'b0, k);
    for (int k = 5; k < 8; k++) exp_beat(32'd0, k == 7, k);
    exp_beat(32'h3AA, 1'b0, 0);
    for (int k = 1; k < 8; k++) exp_beat(32'd0, k == 7, k);
    cmp_q("realign");
`ifdef FFT_FRAMER_STATS_EN
    check("st_pad5", pad_beats, 32'd19);
    check("st_frames5", frames_out, 32'd11);
`endif

    // realign at frame boundary
    clr();
    sop = 1'b1;
    @(posedge clk);
    #1;
    sop = 1'b0;
    idle(2);
    check("sop0_ir", 32'(ir), 32'd1);
    for (int i = 1; i <= 8; i++) send(32'h400 + 32'(i), i == 8);
    idle(4);
    for (int k = 0; k < 8; k++) exp_beat(32'h401 + 32'(k), k == 7, k);
    cmp_q("sop0");
`ifdef FFT_FRAMER_STATS_EN
    check("st_pad6", pad_beats, 32'd19);
`endif

    // reset mid-frame
    clr();
    for (int i = 1; i <= 4; i++) send(32'h500 + 32'(i), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ov", 32'(ov), 32'd0);
    check("mid_rst_idx", 32'(fidx), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) send(32'h600 + 32'(i), i == 8);
    idle(4);
    for (int k = 0; k < 4; k++) exp_beat(32'h501 + 32'(k), 1'b0, k);
    for (int k = 0; k < 8; k++) exp_beat(32'h601 + 32'(k), k == 7, k);
    cmp_q("rstmid");
    nl = 0;
    foreach (q_l[k]) if (q_l[k]) nl++;
    check("rst_lasts", 32'(nl), 32'd1);
`ifdef FFT_FRAMER_STATS_EN
    check("st_frames7", frames_out, 32'd1);
    check("st_pad7", pad_beats, 32'd0);
    check("st_cut7", 32'(cut_frames), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
